// File: rtl/bus_ctrl_gen.sv
// bus_ctrl_gen: external bus controller for the CPU2908 core.
// Accepts one command at a time from the sequencer and runs a SETUP/STROBE/HOLD
// cycle on the device pins, with fixed wait states and nReady stretching.
// nTSC low floats every pin driver and keeps new commands from being accepted.
// Optional feature: define BUS_TIMEOUT_EN to abort an access whose nReady stays
// low for TIMEOUT strobe cycles; it then reports busErr alongside done.

module bus_ctrl_gen #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 0,
    parameter int TIMEOUT     = 64
) (
    input  logic              clkE,
    input  logic              reset,
    input  logic [1:0]        exbusCtrl,
    input  logic [ADDR_W-1:0] addrIn,
    input  logic [DATA_W-1:0] dataIn,
    input  logic [DATA_W-1:0] dataExt,
    input  logic              nReady,
    input  logic              nTSC,
    output logic [ADDR_W-1:0] addrOut,
    output logic [DATA_W-1:0] dataOut,
    output logic              nRD,
    output logic              nWR,
    output logic              nIRQA,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              busErr
);

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_IRQA  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        STROBE = 2'b10,
        HOLD   = 2'b11
    } BusStateT;

    BusStateT          state;
    BusStateT          nextState;
    logic [ADDR_W-1:0] addrReg;
    logic [DATA_W-1:0] dataReg;
    logic [DATA_W-1:0] rdataReg;
    logic [1:0]        cmdReg;
    logic [3:0]        waitCnt;
    logic              accept;
    logic              waitDone;
    logic              timeoutHit;
    logic              errFlag;
    logic              rdLow;
    logic              wrLow;
    logic              irqLow;
    logic              dataDrive;

    // The wait counter is only four bits wide and the timeout needs at least one cycle.
    if (WAIT_STATES < 0 || WAIT_STATES > 15 || TIMEOUT < 1) begin : gBadParams
        $error("bus_ctrl_gen: WAIT_STATES must be 0..15 and TIMEOUT at least 1");
    end

    assign accept   = (state == IDLE) && (exbusCtrl != CMD_IDLE) && nTSC;
    assign waitDone = (waitCnt == 4'd0);

`ifdef BUS_TIMEOUT_EN
    localparam int              TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] toCnt;

    assign timeoutHit = (state == STROBE) && waitDone && !nReady && (toCnt == TO_LAST);

    // Count strobe cycles spent waiting on nReady after the wait states have run out,
    // and remember an abort so the HOLD cycle can flag it on busErr.
    always_ff @(posedge clkE or posedge reset) begin
        if (reset) begin
            toCnt   <= '0;
            errFlag <= 1'b0;
        end else if (state == SETUP) begin
            toCnt   <= '0;
            errFlag <= 1'b0;
        end else if (timeoutHit) begin
            errFlag <= 1'b1;
        end else if ((state == STROBE) && waitDone && !nReady) begin
            toCnt <= toCnt + 1'b1;
        end
    end
`else
    assign timeoutHit = 1'b0;
    assign errFlag    = 1'b0;
`endif

    // State register; reset drops any access in flight straight back to IDLE.
    always_ff @(posedge clkE or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: SETUP and HOLD last one cycle, STROBE waits for the
    // wait counter to drain and then for nReady (or for the timeout abort).
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = SETUP;
            SETUP:   nextState = STROBE;
            STROBE:  if (waitDone && (nReady || timeoutHit)) nextState = HOLD;
            HOLD:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Datapath registers: latch the command on acceptance, run the wait counter,
    // and capture read data on the edge that leaves STROBE. Address and write data
    // are kept after the access so the address bus shows the last address in IDLE.
    always_ff @(posedge clkE or posedge reset) begin
        if (reset) begin
            addrReg  <= '0;
            dataReg  <= '0;
            rdataReg <= '0;
            cmdReg   <= CMD_IDLE;
            waitCnt  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addrReg <= addrIn;
                        dataReg <= dataIn;
                        cmdReg  <= exbusCtrl;
                    end
                end
                SETUP: begin
                    waitCnt <= 4'(WAIT_STATES);
                end
                STROBE: begin
                    if (!waitDone) begin
                        waitCnt <= waitCnt - 1'b1;
                    end else if (cmdReg == CMD_READ) begin
                        if (timeoutHit) begin
                            rdataReg <= '1;
                        end else if (nReady) begin
                            rdataReg <= dataExt;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Decode which strobe is active and whether the write data bus should be driven;
    // only one strobe is ever low because cmdReg selects exactly one of them.
    always_comb begin
        rdLow     = 1'b0;
        wrLow     = 1'b0;
        irqLow    = 1'b0;
        dataDrive = 1'b0;
        if (state == STROBE) begin
            case (cmdReg)
                CMD_READ:  rdLow  = 1'b1;
                CMD_WRITE: wrLow  = 1'b1;
                CMD_IRQA:  irqLow = 1'b1;
                default:   rdLow  = 1'b0;
            endcase
        end
        if ((cmdReg == CMD_WRITE) && ((state == STROBE) || (state == HOLD))) begin
            dataDrive = 1'b1;
        end
    end

    assign addrOut = nTSC ? addrReg : 'z;
    assign dataOut = (nTSC && dataDrive) ? dataReg : 'z;
    assign nRD     = nTSC ? ~rdLow  : 1'bz;
    assign nWR     = nTSC ? ~wrLow  : 1'bz;
    assign nIRQA   = nTSC ? ~irqLow : 1'bz;

    assign rdata  = rdataReg;
    assign busy   = (state != IDLE);
    assign done   = (state == HOLD);
    assign busErr = (state == HOLD) && errFlag;

endmodule

// File: doc/bus_ctrl_gen.md
Name: bus_ctrl_gen

Overview:
- Parametrised external bus controller for the CPU2908 core. It is the next generation of the fixed-width address/data registers and the nRD/nWR/nIRQA strobe flops.
- Accepts one bus command at a time from the sequencer and runs a SETUP/STROBE/HOLD cycle on the external pins.
- Adds programmable wait states and nReady stretching to the existing nTSC bus float.
- Sits between the sequencer/executer internal buses and the device pins.

Parameters:
- ADDR_W, 16, address bus width.
- DATA_W, 8, data bus width.
- WAIT_STATES, 0, fixed extra STROBE cycles per access (0..15).
- TIMEOUT, 64, max STROBE cycles waiting on nReady before abort (only with BUS_TIMEOUT_EN).

Ports:
- clkE  input  1  bus clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- exbusCtrl  input  2  command: 00 idle, 01 read, 10 write, 11 IRQ acknowledge.
- addrIn  input  ADDR_W  transaction address from executer.
- dataIn  input  DATA_W  write data from executer.
- dataExt  input  DATA_W  data bus from pins (read path).
- nReady  input  1  external ready, low = extend strobe.
- nTSC  input  1  low = float all bus outputs and block new transactions.
- addrOut  output  ADDR_W  registered address, Z when nTSC low.
- dataOut  output  DATA_W  registered write data, Z unless a write is in STROBE/HOLD and nTSC high.
- nRD  output  1  read strobe, active low, Z when nTSC low.
- nWR  output  1  write strobe, active low, Z when nTSC low.
- nIRQA  output  1  IRQ acknowledge strobe, active low, Z when nTSC low.
- rdata  output  DATA_W  captured read data.
- busy  output  1  transaction in progress.
- done  output  1  one-cycle completion pulse.
- busErr  output  1  one-cycle timeout pulse (0 without BUS_TIMEOUT_EN).

Behaviour:
- Reset (asynchronous, immediate):
  - state IDLE, addr/data registers 0, rdata 0.
  - busy 0, done 0, busErr 0.
  - nRD/nWR/nIRQA 1 when driven.
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - When exbusCtrl != 00 and nTSC == 1: latch addrIn, dataIn, cmd; go to SETUP; busy = 1 from the next cycle.
  - When nTSC == 0: the command is not accepted. The sequencer holds exbusCtrl until accepted.
- SETUP (1 cycle):
  - addrOut valid, all strobes high.
  - Load the wait counter with WAIT_STATES; go to STROBE.
- STROBE:
  - Assert the selected strobe low: 01 -> nRD, 10 -> nWR, 11 -> nIRQA. Exactly one strobe low at any time.
  - Write: dataOut driven for all of STROBE and HOLD.
  - Counter > 0: decrement, stay.
  - Counter == 0 and nReady == 1: go to HOLD. On a read, capture dataExt into rdata on this edge.
  - Counter == 0 and nReady == 0: stay; strobe remains low.
- HOLD (1 cycle):
  - Strobes high; address and write data still held.
  - done = 1; next state IDLE; busy = 0 from the next cycle.
- Latency with WAIT_STATES = 0 and nReady = 1:
  - Accept edge -> SETUP -> STROBE -> HOLD (done) = 3 cycles.
  - Each wait state or nReady-low cycle adds 1.
- exbusCtrl is ignored while busy, including during HOLD; there is no back-to-back pipelining.
- An IRQ acknowledge (11) performs no data capture; rdata is unchanged.
- nTSC low mid-transaction: outputs float combinationally; the FSM completes normally; done still pulses.
- Reset mid-transaction: aborts to IDLE immediately; no done pulse.
- addrOut keeps the last address in IDLE; it does not return to 0.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in STROBE once the wait counter reaches 0.
  - If nReady is still low after TIMEOUT such cycles, go to HOLD with busErr = 1 for one cycle, concurrent with done.
  - A timed-out read loads rdata with all ones.
- Undefined:
  - nReady may extend STROBE indefinitely.
  - busErr is tied 0.
  - No timeout counter logic is present.

Test Plan:
- Read, WAIT_STATES=0: cmd=01, addrIn=16'h1234, dataExt=8'hA5 -> nRD low exactly 1 cycle, addrOut=1234 from SETUP, rdata=A5, done pulses on cycle 3, busy high cycles 1-3.
- Write, WAIT_STATES=2: cmd=10, addrIn=16'hFF00, dataIn=8'h3C -> nWR low 3 cycles, dataOut=3C through HOLD, Z afterwards, done on cycle 5.
- nReady stretch: read with nReady held low 4 cycles in STROBE -> nRD low 5 cycles, rdata captured only on the nReady-high edge.
- nTSC: nTSC=0 with cmd=01 pending -> all outputs Z, busy stays 0. Raise nTSC -> transaction starts the next cycle.
- Reset during STROBE of a write -> strobes 1 immediately, busy 0, no done; next command runs normally.
- BUS_TIMEOUT_EN, TIMEOUT=8, nReady stuck low on read -> after 8 wait cycles busErr=done=1 together, rdata=8'hFF, return to IDLE.
